// File: rtl/fifo_pkt_tx.sv
// fifo_pkt_tx: drains the 72-bit packet FIFO into a valid/ready egress stream through a small skid buffer.
// Define FIFO_TX_IFG_EN to insert IFG_CYCLES idle cycles after every EOP transfer.
module fifo_pkt_tx #(
  parameter int DWIDTH     = 72,
  parameter int SKID_DEPTH = 3,
  parameter int IFG_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_rdata,
  output logic              reb,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_wr,
  input  logic              out_rdy,
  output logic              out_sop,
  output logic              out_eop,
  output logic              pkt_sent,
  output logic [15:0]       pkt_count,
  output logic              tx_busy
);
  localparam int AW = $clog2(SKID_DEPTH);
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam logic [CW:0] DEPTH = (CW+1)'(SKID_DEPTH);
  localparam logic [AW-1:0] LAST = AW'(SKID_DEPTH - 1);
  if (SKID_DEPTH < 3 || IFG_CYCLES < 1) begin : g_bad_cfg
    $error("fifo_pkt_tx: SKID_DEPTH must be >= 3 and IFG_CYCLES >= 1");
  end
`ifdef FIFO_TX_IFG_EN
  localparam int GW = $clog2(IFG_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, INPKT, GAP} state_t;
  localparam state_t EOP_NX = GAP;
  logic [GW-1:0] gap_cnt;
`else
  typedef enum logic {IDLE, INPKT} state_t;
  localparam state_t EOP_NX = IDLE;
`endif
  state_t state, state_nx;
  logic [DWIDTH-1:0] mem [SKID_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] occ;
  logic inflight, xfer, in_gap;
  // Counting the in-flight read against the buffer is what makes the unconditional capture safe.
  assign reb = !reset && !fifo_empty && ({1'b0, occ} + {{CW{1'b0}}, inflight} < DEPTH);
  always_comb begin
`ifdef FIFO_TX_IFG_EN
    in_gap = state == GAP;
`else
    in_gap = 1'b0;
`endif
    out_data = (occ != '0) ? mem[rd_ptr] : '0;
    out_wr = (occ != '0) && !in_gap;
    out_sop = out_wr && state == IDLE;
    out_eop = out_wr && out_data[DWIDTH-1 -: 8] != 8'h00;
    xfer = out_wr && out_rdy;
    tx_busy = state == INPKT;
`ifdef FIFO_TX_IFG_EN
    state_nx = in_gap ? (gap_cnt == GW'(IFG_CYCLES - 1) ? IDLE : GAP) : xfer ? (out_eop ? EOP_NX : INPKT) : state;
`else
    state_nx = xfer ? (out_eop ? EOP_NX : INPKT) : state;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      occ <= '0;
      inflight <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      pkt_sent <= 1'b0;
      pkt_count <= '0;
    end else begin
      state <= state_nx;
      inflight <= reb;
      occ <= occ + CW'(inflight) - CW'(xfer);
      if (inflight) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (xfer) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      pkt_sent <= xfer && out_eop;
      pkt_count <= pkt_count + 16'(xfer && out_eop);
    end
  end
  always_ff @(posedge clk) if (inflight && !reset) mem[wr_ptr] <= fifo_rdata;
`ifdef FIFO_TX_IFG_EN
  always_ff @(posedge clk) gap_cnt <= (reset || !in_gap) ? '0 : gap_cnt + 1'b1;
`endif
endmodule
